// File: rtl/seg7_pkg.sv
// Shared constants and types for the six-digit multiplexed seven-segment display.
// All segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  typedef logic [2:0] idx_t;

  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_OFF  = 7'h7F;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 6'h3F;
  localparam idx_t IDX_LAST = 3'd5;

  // Separators sit after the hours and minutes digit pairs (hh.mm.ss).
  function automatic logic is_dp_slot(input idx_t idx);
    return (idx == 3'd2) || (idx == 3'd4);
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Display bus between the time-keeping logic (master) and the scanner (slave).
interface seg7_scan_if;
  import seg7_pkg::*;

  logic                  enable;
  logic                  tick_1hz;
  bcd_t                  count0;
  bcd_t                  count1;
  bcd_t                  count2;
  bcd_t                  count3;
  bcd_t                  count4;
  bcd_t                  count5;
  logic [NUM_DIGITS-1:0] an;
  seg_t                  seg;
  logic                  dp;

  modport master (
    output enable, tick_1hz, count0, count1, count2, count3, count4, count5,
    input  an, seg, dp
  );

  modport slave (
    input  enable, tick_1hz, count0, count1, count2, count3, count4, count5,
    output an, seg, dp
  );

endinterface

// File: rtl/seg7_scan_bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  // Pattern lookup
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Six-digit multiplexed seven-segment scanner with a per-frame snapshot of the time digits.
// Optional build macro COLON_BLINK_EN makes the hh.mm.ss separators blink from tick_1hz.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  seg7_scan_if.slave bus
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]      div_q, div_d;
  idx_t                  idx_q, idx_d;
  bcd_t                  snap_q [NUM_DIGITS];
  bcd_t                  snap_d [NUM_DIGITS];
  bcd_t                  counts_s [NUM_DIGITS];
  logic                  dp_lit_q, dp_lit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  slot_tick_s;
  bcd_t                  digit_s;
  seg_t                  seg_dec_s;

  // Gather the live digits in index order
  always_comb begin
    counts_s[0] = bus.count0;
    counts_s[1] = bus.count1;
    counts_s[2] = bus.count2;
    counts_s[3] = bus.count3;
    counts_s[4] = bus.count4;
    counts_s[5] = bus.count5;
  end

  // Divider, digit index and frame snapshot; everything holds while disabled
  always_comb begin
    div_d       = div_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    slot_tick_s = 1'b0;
    if (bus.enable) begin
      slot_tick_s = (div_q == DIV_LAST);
      if (slot_tick_s) begin
        div_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d  = 3'd0;
          snap_d = counts_s;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = div_q;
    end
  end

`ifdef COLON_BLINK_EN
  // Separator phase flips once per second
  always_comb begin
    if (bus.enable && bus.tick_1hz) begin
      dp_lit_d = ~dp_lit_q;
    end else begin
      dp_lit_d = dp_lit_q;
    end
  end
`else
  logic unused_tick_s;
  assign unused_tick_s = bus.tick_1hz;
  assign dp_lit_d      = 1'b1;
`endif

  // Snapshot mux, driven from the next index so outputs line up with idx_q
  always_comb begin
    case (idx_d)
      3'd0:    digit_s = snap_d[0];
      3'd1:    digit_s = snap_d[1];
      3'd2:    digit_s = snap_d[2];
      3'd3:    digit_s = snap_d[3];
      3'd4:    digit_s = snap_d[4];
      3'd5:    digit_s = snap_d[5];
      default: digit_s = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (digit_s),
    .seg (seg_dec_s)
  );

  // Next display outputs
  always_comb begin
    if (bus.enable) begin
      an_d  = ~(6'd1 << idx_d);
      seg_d = seg_dec_s;
      dp_d  = ~(dp_lit_d & is_dp_slot(idx_d));
    end else begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      idx_q    <= 3'd0;
      dp_lit_q <= 1'b1;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        snap_q[i] <= 4'd0;
      end
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      dp_lit_q <= dp_lit_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      snap_q   <= snap_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with SCAN_DIV=4: frames, mid-frame updates, hold, blink, reset.
module tb_seg7_scan;
  import seg7_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic dp_lit_exp;

  // Hand-decoded frames: index 0..5 = count0..count5
  logic [6:0] tbl_a [6] = '{7'h10, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] tbl_b [6] = '{7'h30, 7'h12, 7'h19, 7'h3F, 7'h24, 7'h79};

  seg7_scan_if bus ();

  seg7_scan #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_blank(input string tag);
    check_eq({tag, " an"},  32'(bus.an),  32'h3F);
    check_eq({tag, " seg"}, 32'(bus.seg), 32'h7F);
    check_eq({tag, " dp"},  32'(bus.dp),  32'h1);
  endtask

  initial begin
    logic [5:0] an_exp;
    logic [6:0] seg_exp;
    logic       dp_exp;
    int         ncyc;

    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.count5   = 4'd1;
    bus.count4   = 4'd2;
    bus.count3   = 4'd3;
    bus.count2   = 4'd4;
    bus.count1   = 4'd5;
    bus.count0   = 4'd9;
    dp_lit_exp   = 1'b1;

    repeat (4) begin
      @(negedge clk);
      check_blank("reset");
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_blank("idle");
    end

    bus.enable = 1'b1;
    for (int f = 0; f < 7; f++) begin
      for (int s = 0; s < 6; s++) begin
        ncyc = (f == 0 && s == 0) ? 3 : 4;
        for (int c = 0; c < ncyc; c++) begin
          @(negedge clk);
          an_exp  = ~(6'd1 << s);
          seg_exp = (f == 0) ? 7'h40 : ((f < 3) ? tbl_a[s] : tbl_b[s]);
          dp_exp  = ((s == 2 || s == 4) && dp_lit_exp) ? 1'b0 : 1'b1;
          check_eq($sformatf("an f%0d s%0d c%0d", f, s, c),  32'(bus.an),  32'(an_exp));
          check_eq($sformatf("seg f%0d s%0d c%0d", f, s, c), 32'(bus.seg), 32'(seg_exp));
          check_eq($sformatf("dp f%0d s%0d c%0d", f, s, c),  32'(bus.dp),  32'(dp_exp));

          bus.tick_1hz = 1'b0;
          if (f == 2 && s == 2 && c == 0) begin
            bus.count0 = 4'd3;
            bus.count3 = 4'd12;
          end
          if ((f == 5 || f == 6) && s == 0 && c == 0) begin
            bus.tick_1hz = 1'b1;
`ifdef COLON_BLINK_EN
            dp_lit_exp = ~dp_lit_exp;
`endif
          end
          if (f == 4 && s == 3 && c == 1) begin
            bus.enable = 1'b0;
            repeat (10) begin
              @(negedge clk);
              check_blank("hold");
            end
            bus.enable = 1'b1;
          end
        end
      end
    end

    // Mid-frame reset: snapshot and index restart from zero
    bus.tick_1hz = 1'b0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_blank("midreset");
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("post-reset an0",  32'(bus.an),  32'h3E);
      check_eq("post-reset seg0", 32'(bus.seg), 32'h40);
    end
    @(negedge clk);
    check_eq("post-reset an1",  32'(bus.an),  32'h3D);
    check_eq("post-reset seg1", 32'(bus.seg), 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
